// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: one word request in, fixed wait states,
// one response out over its own valid/ready handshake. One transaction in flight.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_EXEC,
        S_RESP
    } state_t;

    state_t           state;
    logic [3:0]       wait_cnt;
    logic             op_write;
    logic [31:0]      op_addr;
    logic [31:0]      op_wdata;
    logic [31:0]      mem [DEPTH];
    logic             op_error;
    logic [IDX_W-1:0] op_idx;

    // Word index is compared at full 30-bit width so large addresses never alias.
    always_comb begin
        op_idx   = op_addr[IDX_W+1:2];
        op_error = (op_addr[1:0] != 2'b00) || ({2'b00, op_addr[31:2]} >= 32'(DEPTH));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            op_write   <= 1'b0;
            op_addr    <= '0;
            op_wdata   <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            busy       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_write  <= req_write;
                        op_addr   <= req_addr;
                        op_wdata  <= req_wdata;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_EXEC;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    resp_error <= op_error;
                    resp_rdata <= (op_write || op_error) ? 32'h0 : mem[op_idx];
                    if (op_write && !op_error) begin
                        mem[op_idx] <= op_wdata;
                    end
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    // Response fields hold until the requester takes them.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_error <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
